// File: rtl/eskimo_video_pkg.sv
// Shared video timing constants and pixel types for the sprite/VGA path.
// Used by the line-buffer scanout and its RAM banks.
package eskimo_video_pkg;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_TOTAL  = 10'd800;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_TOTAL  = 10'd525;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t BG_COLOR_DEFAULT = '{r: 8'h00, g: 8'h00, b: 8'h00};

    typedef enum logic {
        FILL_PENDING,
        FILL_READY
    } fill_state_t;

endpackage

// File: rtl/lb_bank.sv
// One line bank: port A writes from the sprite engine, port B reads
// old data asynchronously and clears the entry in the same clock.
module lb_bank
    import eskimo_video_pkg::*;
#(
    parameter int DEPTH = 640
) (
    input  logic       clk,
    input  logic       wr_en,
    input  logic [9:0] wr_addr,
    input  rgb_t       wr_data,
    input  logic [9:0] rd_addr,
    input  logic       clr_en,
    input  rgb_t       clr_data,
    output rgb_t       rd_data
);

    rgb_t mem [DEPTH];

    assign rd_data = mem[rd_addr];

    // Writer and clear never hit the same bank in one cycle
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end else if (clr_en) begin
            mem[rd_addr] <= clr_data;
        end
    end

endmodule

// File: rtl/line_buffer_scanout.sv
// Ping-pong line buffer scanout to VGA with clear-on-read and underrun blanking.
// Optional LB_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module line_buffer_scanout
    import eskimo_video_pkg::*;
#(
    parameter rgb_t BG_COLOR = BG_COLOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  VGA_HCOUNT,
    input  logic [9:0]  VGA_VCOUNT,
    input  logic        wr_en,
    input  logic [9:0]  wr_x,
    input  logic [23:0] wr_data,
    input  logic        wr_line_done,
    output logic        wr_req,
    output logic [9:0]  wr_line,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
`ifdef LB_UNDERRUN_CNT_EN
    output logic [7:0]  VGA_B,
    output logic [15:0] underrun_cnt
`else
    output logic [7:0]  VGA_B
`endif
);

    fill_state_t state;
    fill_state_t state_nxt;

    logic       rd_bank;
    logic       blank;
    logic       swap;
    logic       rd_act;
    logic       wr_ok;
    logic       underrun;
    logic [9:0] line_next;
    rgb_t       rd0;
    rgb_t       rd1;
    rgb_t       rd_pix;

    assign swap     = (VGA_HCOUNT == H_TOTAL - 10'd1);
    assign rd_act   = (VGA_HCOUNT < H_ACTIVE) && (VGA_VCOUNT < V_ACTIVE);
    assign wr_ok    = wr_en && (wr_x < H_ACTIVE);
    assign underrun = swap && (state == FILL_PENDING) && !wr_line_done;
    assign rd_pix   = rd_bank ? rd1 : rd0;

    lb_bank #(.DEPTH(640)) u_bank0 (
        .clk      (clk),
        .wr_en    (wr_ok && rd_bank),
        .wr_addr  (wr_x),
        .wr_data  (rgb_t'(wr_data)),
        .rd_addr  (VGA_HCOUNT),
        .clr_en   (rd_act && !rd_bank),
        .clr_data (BG_COLOR),
        .rd_data  (rd0)
    );

    lb_bank #(.DEPTH(640)) u_bank1 (
        .clk      (clk),
        .wr_en    (wr_ok && !rd_bank),
        .wr_addr  (wr_x),
        .wr_data  (rgb_t'(wr_data)),
        .rd_addr  (VGA_HCOUNT),
        .clr_en   (rd_act && rd_bank),
        .clr_data (BG_COLOR),
        .rd_data  (rd1)
    );

    // Line the freshly swapped write bank will be shown on, wrapping the frame
    always_comb begin
        line_next = VGA_VCOUNT + 10'd2;
        if (VGA_VCOUNT >= V_TOTAL - 10'd2) begin
            line_next = VGA_VCOUNT - (V_TOTAL - 10'd2);
        end
    end

    // Writer-complete tracking: a swap always restarts the fill
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL_PENDING;
        end else begin
            state <= state_nxt;
        end
    end

    // Done is sticky until the swap point consumes it
    always_comb begin
        state_nxt = state;
        if (swap) begin
            state_nxt = FILL_PENDING;
        end else if (wr_line_done) begin
            state_nxt = FILL_READY;
        end
    end

    // Bank swap, writer request and per-line underrun blanking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_bank <= 1'b0;
            wr_req  <= 1'b0;
            wr_line <= '0;
            blank   <= 1'b1;
        end else begin
            wr_req <= swap;
            if (swap) begin
                rd_bank <= ~rd_bank;
                wr_line <= line_next;
                blank   <= underrun;
            end
        end
    end

    // Registered pixel output, black outside the visible window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {VGA_R, VGA_G, VGA_B} <= '0;
        end else if (rd_act) begin
            {VGA_R, VGA_G, VGA_B} <= blank ? BG_COLOR : rd_pix;
        end else begin
            {VGA_R, VGA_G, VGA_B} <= '0;
        end
    end

`ifdef LB_UNDERRUN_CNT_EN
    // Saturating count of lines shown blank because the writer was late
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun_cnt <= '0;
        end else if (underrun && underrun_cnt != 16'hFFFF) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_line_buffer_scanout.sv
// Directed bench for line_buffer_scanout with a line-level reference model.
// Build with LB_UNDERRUN_CNT_EN to also check the underrun counter.
module tb_line_buffer_scanout;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  VGA_HCOUNT;
    logic [9:0]  VGA_VCOUNT;
    logic        wr_en;
    logic [9:0]  wr_x;
    logic [23:0] wr_data;
    logic        wr_line_done;
    logic        wr_req;
    logic [9:0]  wr_line;
    logic [7:0]  VGA_R;
    logic [7:0]  VGA_G;
    logic [7:0]  VGA_B;
`ifdef LB_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    line_buffer_scanout dut (
        .clk          (clk),
        .reset        (reset),
        .VGA_HCOUNT   (VGA_HCOUNT),
        .VGA_VCOUNT   (VGA_VCOUNT),
        .wr_en        (wr_en),
        .wr_x         (wr_x),
        .wr_data      (wr_data),
        .wr_line_done (wr_line_done),
        .wr_req       (wr_req),
        .wr_line      (wr_line),
        .VGA_R        (VGA_R),
        .VGA_G        (VGA_G),
`ifdef LB_UNDERRUN_CNT_EN
        .VGA_B        (VGA_B),
        .underrun_cnt (underrun_cnt)
`else
        .VGA_B        (VGA_B)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rgb();
        return {8'h00, VGA_R, VGA_G, VGA_B};
    endfunction

    // ---------------- reference model (line-level) ----------------
    logic [23:0] dbuf [640];
    logic [23:0] wbuf [640];
    bit          dk   [640];
    bit          wk   [640];
    bit          m_ready;
    bit          m_blank;
    bit          m_req;
    int          m_line;
    int          m_cnt;

    task automatic m_reset();
        for (int i = 0; i < 640; i++) begin
            dk[i] = 1'b0;
            wk[i] = 1'b0;
        end
        m_ready = 1'b0;
        m_blank = 1'b1;
        m_req   = 1'b0;
        m_line  = 0;
        m_cnt   = 0;
    endtask

    initial begin
        int          h;
        int          v;
        bit          e_ok;
        logic [31:0] e_rgb;
        logic [23:0] t;
        bit          tk;
        m_reset();
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                m_reset();
                chk("reset_rgb", rgb(), 32'h0);
                chk("reset_wr_req", 32'(wr_req), 32'h0);
                chk("reset_wr_line", 32'(wr_line), 32'h0);
            end else begin
                h = int'(VGA_HCOUNT);
                v = int'(VGA_VCOUNT);
                e_ok = 1'b1;
                e_rgb = 32'h0;
                if (h < 640 && v < 480) begin
                    if (m_blank) e_rgb = 32'h0;
                    else if (dk[h]) e_rgb = {8'h00, dbuf[h]};
                    else e_ok = 1'b0;
                    dbuf[h] = 24'h0;
                    dk[h] = 1'b1;
                end
                if (wr_en && int'(wr_x) < 640) begin
                    wbuf[wr_x] = wr_data;
                    wk[wr_x] = 1'b1;
                end
                if (wr_line_done) m_ready = 1'b1;
                m_req = (h == 799);
                if (h == 799) begin
                    m_blank = !m_ready;
                    if (!m_ready && m_cnt < 65535) m_cnt++;
                    m_line = (v + 2) % 525;
                    m_ready = 1'b0;
                    for (int i = 0; i < 640; i++) begin
                        t = dbuf[i]; dbuf[i] = wbuf[i]; wbuf[i] = t;
                        tk = dk[i]; dk[i] = wk[i]; wk[i] = tk;
                    end
                end
                if (e_ok) chk("model_rgb", rgb(), e_rgb);
                chk("model_wr_req", 32'(wr_req), 32'(m_req));
                chk("model_wr_line", 32'(wr_line), 32'(m_line));
`ifdef LB_UNDERRUN_CNT_EN
                chk("model_underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
`endif
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int          w_h [$];
    int          w_x [$];
    logic [23:0] w_d [$];
    int          p_h [$];
    logic [31:0] p_v [$];
    int          done_h = -1;
    int          rst_h = -1;
    bit          prev_line = 1'b0;

    task automatic wr(input int h, input int x, input logic [23:0] d);
        w_h.push_back(h);
        w_x.push_back(x);
        w_d.push_back(d);
    endtask

    task automatic px(input int x, input logic [31:0] val);
        p_h.push_back(x + 1);
        p_v.push_back(val);
    endtask

    task automatic run_line(input int v);
        for (int h = 0; h < 800; h++) begin
            @(negedge clk);
            if (rst_h >= 0 && h == rst_h + 1) reset = 1'b1;
            if (prev_line && h == 0) chk("wr_req_pulse", 32'(wr_req), 32'h1);
            if (prev_line && h == 1) chk("wr_req_clear", 32'(wr_req), 32'h0);
            foreach (p_h[i]) begin
                if (p_h[i] == h) chk($sformatf("pixel_v%0d_x%0d", v, h - 1), rgb(), p_v[i]);
            end
            VGA_HCOUNT = 10'(h);
            VGA_VCOUNT = 10'(v);
            wr_en = 1'b0;
            wr_x = '0;
            wr_data = '0;
            wr_line_done = (h == done_h);
            foreach (w_h[i]) begin
                if (w_h[i] == h) begin
                    wr_en = 1'b1;
                    wr_x = 10'(w_x[i]);
                    wr_data = w_d[i];
                end
            end
            if (h == rst_h) begin
                #2 reset = 1'b0;
                #1;
                chk("async_reset_rgb", rgb(), 32'h0);
                chk("async_reset_wr_line", 32'(wr_line), 32'h0);
            end
        end
        prev_line = 1'b1;
        w_h.delete(); w_x.delete(); w_d.delete();
        p_h.delete(); p_v.delete();
        done_h = -1;
        rst_h = -1;
    endtask

    task automatic chk_swap_line(input int e);
        @(posedge clk);
        #1;
        chk("wr_line_after_swap", 32'(wr_line), 32'(e));
    endtask

`ifdef LB_UNDERRUN_CNT_EN
    task automatic chk_cnt(input int e);
        @(posedge clk);
        #1;
        chk("underrun_cnt", 32'(underrun_cnt), 32'(e));
    endtask
`endif

    initial begin
        reset = 1'b0;
        VGA_HCOUNT = '0;
        VGA_VCOUNT = '0;
        wr_en = 1'b0;
        wr_x = '0;
        wr_data = '0;
        wr_line_done = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // no writer activity: blank lines, one request per line
        run_line(0);
        px(100, 32'h0);
        run_line(1);
        run_line(2);

        // single red pixel
        wr(100, 5, 24'hFF0000); done_h = 200;
        run_line(3);
        chk_swap_line(5);
        px(4, 32'h0); px(5, 32'hFF0000); px(6, 32'h0); done_h = 50;
        run_line(4);
        done_h = 50;
        run_line(5);

        // cleared on read; out-of-range write dropped
        px(5, 32'h0); wr(300, 640, 24'hFFFFFF); done_h = 400;
        run_line(6);
        px(0, 32'h0); wr(100, 10, 24'h0000FF);
        run_line(7);
`ifdef LB_UNDERRUN_CNT_EN
        chk_cnt(4);
`endif
        px(10, 32'h0); done_h = 10;
        run_line(8);
        done_h = 10;
        run_line(9);

        // write and done in the swap cycle
        px(10, 32'h0); wr(799, 3, 24'h00FF00); done_h = 799;
        run_line(10);
`ifdef LB_UNDERRUN_CNT_EN
        chk_cnt(4);
`endif
        px(3, 32'h00FF00);
        wr(10, 7, 24'h111111); wr(20, 7, 24'h222222); done_h = 30;
        run_line(11);
        px(7, 32'h222222); done_h = 10; wr(500, 9, 24'hABCDEF);
        run_line(12);
        px(9, 32'hABCDEF); wr(5, 2, 24'h123456); done_h = 6;
        run_line(13);

        // blanking lines do not clear; wr_line wraps
        done_h = 1;
        run_line(523);
        chk_swap_line(0);
        done_h = 1;
        run_line(524);
        chk_swap_line(1);
        px(2, 32'h123456); wr(400, 299, 24'hFFFFFF); done_h = 500;
        run_line(0);

        // asynchronous reset mid-line, then recovery
        px(299, 32'hFFFFFF); rst_h = 300;
        run_line(1);
        px(1, 32'h0); wr(10, 1, 24'h0000AA); done_h = 20;
        run_line(2);
        px(1, 32'h0000AA); done_h = 5;
        run_line(3);

        @(negedge clk);
        VGA_HCOUNT = 10'd700;
        VGA_VCOUNT = 10'd0;
        wr_line_done = 1'b0;
        wr_en = 1'b0;
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
